ad7352_rx: RTL

Serial receiver for the dual AD7352 converter pair that digitises the power stage (capacitor voltage/current, output voltage/current). Owns `ad_cs`, runs back-to-back conversions, deserialises four 12-bit channels from two 2-bit data buses, and presents one coherent sample set per frame with a valid strobe. Sits inside `blaster` between the ADC pins and the PWM current regulator.

---
 rtl/ad7352_rx_if.sv | 23 ++
 rtl/ad7352_rx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ad7352_rx_if.sv
// Pin and sample bus between the AD7352 pair and the receiver.
// The receiver owns ad_cs and the sample outputs; the ADC side drives the data lanes.
interface ad7352_rx_if;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a;
    logic [1:0]  ad_sdata_b;
    logic [11:0] vcap;
    logic [11:0] icap;
    logic [11:0] vout;
    logic [11:0] iout;
    logic        valid;
    logic        frame_err;

    modport master (
        output ad_cs, vcap, icap, vout, iout, valid, frame_err,
        input  ad_sdata_a, ad_sdata_b
    );

    modport slave (
        input  ad_cs, vcap, icap, vout, iout, valid, frame_err,
        output ad_sdata_a, ad_sdata_b
    );
endinterface

// File: rtl/ad7352_rx.sv
// Dual AD7352 receiver: continuous framed conversions, four 12-bit channels, one valid per frame.
// Optional leading-zero framing check enabled by defining ADC_RX_LEADZERO_CHECK_EN.
//
// state | meaning
// IDLE  | ad_cs high, waiting for run
// QUIET | ad_cs high, CS_HIGH_CYCLES quiet time between frames
// LEADZ | ad_cs low, leading-zero slot sampled on exit
// SHIFT | ad_cs low, 12 data bits shifted MSB first
// LOAD  | ad_cs low, first edge copies samples and pulses valid, second edge ends frame
module ad7352_rx #(
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    ad7352_rx_if.master  bus
);
    localparam int QW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [QW-1:0] QUIET_LOAD = QW'(CS_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, QUIET, LEADZ, SHIFT, LOAD} state_t;

    state_t      state;
    logic [QW-1:0] q_cnt;
    logic [3:0]  bit_cnt;
    logic        load_done;
    logic        cs_r;
    logic        valid_r;
    logic        err_r;
    logic [11:0] sr_vcap, sr_icap, sr_vout, sr_iout;
    logic [11:0] vcap_r, icap_r, vout_r, iout_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            q_cnt     <= '0;
            bit_cnt   <= '0;
            load_done <= 1'b0;
            cs_r      <= 1'b1;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            sr_vcap   <= '0;
            sr_icap   <= '0;
            sr_vout   <= '0;
            sr_iout   <= '0;
            vcap_r    <= '0;
            icap_r    <= '0;
            vout_r    <= '0;
            iout_r    <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    cs_r <= 1'b1;
                    if (run) begin
                        state <= QUIET;
                        q_cnt <= QUIET_LOAD;
                    end
                end
                QUIET: begin
                    if (q_cnt == '0) begin
                        state <= LEADZ;
                        cs_r  <= 1'b0;
                    end else begin
                        q_cnt <= q_cnt - 1'b1;
                    end
                end
                LEADZ: begin
                    state   <= SHIFT;
                    bit_cnt <= 4'd11;
`ifdef ADC_RX_LEADZERO_CHECK_EN
                    if (|{bus.ad_sdata_a, bus.ad_sdata_b})
                        err_r <= 1'b1;
`endif
                end
                SHIFT: begin
                    sr_vout <= {sr_vout[10:0], bus.ad_sdata_a[1]};
                    sr_iout <= {sr_iout[10:0], bus.ad_sdata_a[0]};
                    sr_vcap <= {sr_vcap[10:0], bus.ad_sdata_b[1]};
                    sr_icap <= {sr_icap[10:0], bus.ad_sdata_b[0]};
                    if (bit_cnt == 4'd0) begin
                        state     <= LOAD;
                        load_done <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                LOAD: begin
                    if (!load_done) begin
                        // All four channels land on the same edge so consumers never see a mixed set.
                        vcap_r    <= sr_vcap;
                        icap_r    <= sr_icap;
                        vout_r    <= sr_vout;
                        iout_r    <= sr_iout;
                        valid_r   <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        cs_r <= 1'b1;
                        if (run) begin
                            state <= QUIET;
                            q_cnt <= QUIET_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cs_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ad_cs     = cs_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = err_r;
    assign bus.vcap      = vcap_r;
    assign bus.icap      = icap_r;
    assign bus.vout      = vout_r;
    assign bus.iout      = iout_r;
endmodule
